// File: rtl/piece_queue_pkg.sv
// Shared types for the piece queue: the piece code, the illegal-code marker,
// the sequencer states and a legality helper.
package piece_queue_pkg;

  typedef logic [2:0] piece_t;

  localparam piece_t PIECE_INVALID = 3'd7;
  localparam int     PREVIEW_N     = 3;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  function automatic logic is_legal(input piece_t p);
    return (p != PIECE_INVALID);
  endfunction

endpackage

// File: rtl/piece_queue_if.sv
// Generator handshake, game-logic requests and piece/preview status bundled
// into one interface; master is the game/generator side, slave is the queue.
interface piece_queue_if;
  import piece_queue_pkg::*;

  logic                     gen_ready;
  piece_t                   gen_piece;
  logic                     gen_take;
  logic                     spawn_req;
  logic                     hold_req;
  logic                     spawn_valid;
  piece_t                   active_piece;
  piece_t                   hold_piece;
  logic                     hold_valid;
  logic [3*PREVIEW_N-1:0]   preview;
  logic [PREVIEW_N-1:0]     preview_valid;
  logic                     err_invalid;

  modport master (
    output gen_ready, gen_piece, spawn_req, hold_req,
    input  gen_take, spawn_valid, active_piece, hold_piece, hold_valid,
           preview, preview_valid, err_invalid
  );

  modport slave (
    input  gen_ready, gen_piece, spawn_req, hold_req,
    output gen_take, spawn_valid, active_piece, hold_piece, hold_valid,
           preview, preview_valid, err_invalid
  );

endinterface

// File: rtl/piece_queue_fifo.sv
// Shift-style FIFO of piece codes: entry 0 is always the head, so every slot
// can be peeked directly for the preview.
module piece_fifo
  import piece_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  piece_t               push_data,
  input  logic                 pop,
  output logic [CW-1:0]        count,
  output piece_t [DEPTH-1:0]   entries
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  piece_t [DEPTH-1:0] mem_r;
  piece_t [DEPTH-1:0] shifted_s;
  piece_t [DEPTH-1:0] mem_n_s;
  logic [CW-1:0]      count_r;
  logic [CW-1:0]      count_n_s;
  logic [CW-1:0]      wr_idx_s;
  logic               do_pop_s;
  logic               do_push_s;

  assign do_pop_s  = pop && (count_r != {CW{1'b0}});
  assign do_push_s = push && ((count_r != FULL_COUNT) || do_pop_s);
  // A same-cycle pop frees the slot just below the current tail.
  assign wr_idx_s  = do_pop_s ? (count_r - CW'(1)) : count_r;

  // Next storage contents: optional shift toward the head, then tail write.
  always_comb begin
    shifted_s = mem_r;
    if (do_pop_s) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        shifted_s[i] = mem_r[i + 1];
      end
      shifted_s[DEPTH-1] = 3'd0;
    end else begin
      shifted_s = mem_r;
    end
    mem_n_s = shifted_s;
    for (int i = 0; i < DEPTH; i++) begin
      if (do_push_s && (wr_idx_s == CW'(i))) begin
        mem_n_s[i] = push_data;
      end else begin
        mem_n_s[i] = shifted_s[i];
      end
    end
  end

  // Next occupancy count.
  always_comb begin
    count_n_s = count_r;
    case ({do_push_s, do_pop_s})
      2'b10:   count_n_s = count_r + CW'(1);
      2'b01:   count_n_s = count_r - CW'(1);
      default: count_n_s = count_r;
    endcase
  end

  // Storage and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_r   <= '{default: 3'd0};
      count_r <= {CW{1'b0}};
    end else begin
      mem_r   <= mem_n_s;
      count_r <= count_n_s;
    end
  end

  assign count   = count_r;
  assign entries = mem_r;

endmodule

// File: rtl/piece_queue.sv
// Upcoming-piece queue with hold slot: fills from the generator, hands pieces
// to the game on spawn, and supports one hold/swap per spawned piece.
module piece_queue
  import piece_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  piece_queue_if.slave bus
);

  localparam int            CW         = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  state_t             state_r;
  state_t             state_n_s;
  logic [CW-1:0]      count_s;
  piece_t [DEPTH-1:0] entries_s;
  logic               pop_s;
  logic               capture_s;
  logic               push_s;
  logic               load_head_s;
  logic               load_gen_s;
  logic               park_s;
  logic               swap_s;
  piece_t             active_piece_r;
  logic               active_valid_r;
  piece_t             hold_piece_r;
  logic               hold_valid_r;
  logic               hold_allowed_r;
  logic               spawn_valid_r;
  logic               err_invalid_r;
  logic [3*PREVIEW_N-1:0] preview_s;
  logic [PREVIEW_N-1:0]   preview_valid_s;

  // While waiting the queue is empty, so the generator is always accepted there.
  assign capture_s = bus.gen_ready && ((count_s != FULL_COUNT) || pop_s);
  assign push_s    = capture_s && is_legal(bus.gen_piece) && (state_r != ST_WAIT);

  piece_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (bus.gen_piece),
    .pop       (pop_s),
    .count     (count_s),
    .entries   (entries_s)
  );

  // Sequencer next state and per-cycle action strobes.
  always_comb begin
    state_n_s   = state_r;
    pop_s       = 1'b0;
    load_head_s = 1'b0;
    load_gen_s  = 1'b0;
    park_s      = 1'b0;
    swap_s      = 1'b0;
    case (state_r)
      ST_FILL: begin
        if (count_s == FULL_COUNT) begin
          state_n_s = ST_RUN;
        end else begin
          state_n_s = ST_FILL;
        end
      end
      ST_RUN: begin
        if (bus.spawn_req) begin
          if (count_s != {CW{1'b0}}) begin
            pop_s       = 1'b1;
            load_head_s = 1'b1;
          end else begin
            state_n_s = ST_WAIT;
          end
        end else if (bus.hold_req && hold_allowed_r) begin
          if (hold_valid_r) begin
            swap_s = 1'b1;
          end else if (active_valid_r) begin
            park_s = 1'b1;
            if (count_s != {CW{1'b0}}) begin
              pop_s       = 1'b1;
              load_head_s = 1'b1;
            end else begin
              state_n_s = ST_WAIT;
            end
          end else begin
            state_n_s = ST_RUN;
          end
        end else begin
          state_n_s = ST_RUN;
        end
      end
      ST_WAIT: begin
        if (bus.gen_ready && is_legal(bus.gen_piece)) begin
          load_gen_s = 1'b1;
          state_n_s  = ST_RUN;
        end else begin
          state_n_s = ST_WAIT;
        end
      end
      default: state_n_s = ST_FILL;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_FILL;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Active/hold slots and the one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_piece_r <= 3'd0;
      active_valid_r <= 1'b0;
      hold_piece_r   <= 3'd0;
      hold_valid_r   <= 1'b0;
      hold_allowed_r <= 1'b0;
      spawn_valid_r  <= 1'b0;
      err_invalid_r  <= 1'b0;
    end else begin
      spawn_valid_r <= load_head_s || load_gen_s || swap_s;
      err_invalid_r <= capture_s && !is_legal(bus.gen_piece);
      if (swap_s) begin
        active_piece_r <= hold_piece_r;
        hold_piece_r   <= active_piece_r;
        hold_allowed_r <= 1'b0;
      end else if (park_s) begin
        // Parking always consumes the hold right, even when a spawn follows.
        hold_piece_r   <= active_piece_r;
        hold_valid_r   <= 1'b1;
        hold_allowed_r <= 1'b0;
        if (load_head_s) begin
          active_piece_r <= entries_s[0];
        end else begin
          active_valid_r <= 1'b0;
        end
      end else if (load_head_s) begin
        active_piece_r <= entries_s[0];
        active_valid_r <= 1'b1;
        hold_allowed_r <= 1'b1;
      end else if (load_gen_s) begin
        active_piece_r <= bus.gen_piece;
        active_valid_r <= 1'b1;
        hold_allowed_r <= 1'b1;
      end
    end
  end

  // Preview shows the entries behind the head, blanked when not occupied.
  for (genvar i = 0; i < PREVIEW_N; i++) begin : g_prev
    if (i + 1 < DEPTH) begin : g_on
      assign preview_valid_s[i]  = (count_s > CW'(i + 1));
      assign preview_s[3*i +: 3] = preview_valid_s[i] ? entries_s[i+1] : 3'd0;
    end else begin : g_off
      assign preview_valid_s[i]  = 1'b0;
      assign preview_s[3*i +: 3] = 3'd0;
    end
  end

  assign bus.gen_take      = capture_s;
  assign bus.spawn_valid   = spawn_valid_r;
  assign bus.active_piece  = active_piece_r;
  assign bus.hold_piece    = hold_piece_r;
  assign bus.hold_valid    = hold_valid_r;
  assign bus.preview       = preview_s;
  assign bus.preview_valid = preview_valid_s;
  assign bus.err_invalid   = err_invalid_r;

endmodule

// File: tb/tb_piece_queue.sv
// Directed bench for piece_queue: fill, spawn, hold/swap, empty wait,
// illegal codes, full-queue pop+capture and reset abandonment.
module tb_piece_queue;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  piece_queue_if bus();

  piece_queue #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic gr, input logic [2:0] gp, input logic sp, input logic hr);
    bus.gen_ready = gr;
    bus.gen_piece = gp;
    bus.spawn_req = sp;
    bus.hold_req  = hr;
  endtask

  initial begin
    logic [2:0] fill_a [4];
    logic [2:0] fill_b [4];
    fill_a = '{3'd3, 3'd1, 3'd4, 3'd0};
    fill_b = '{3'd2, 3'd5, 3'd1, 3'd3};

    reset = 1'b1;
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_spawn_valid", 16'(bus.spawn_valid), 16'd0);
    chk("rst_active", 16'(bus.active_piece), 16'd0);
    chk("rst_hold_valid", 16'(bus.hold_valid), 16'd0);
    chk("rst_hold", 16'(bus.hold_piece), 16'd0);
    chk("rst_preview", 16'(bus.preview), 16'd0);
    chk("rst_pvalid", 16'(bus.preview_valid), 16'd0);
    chk("rst_err", 16'(bus.err_invalid), 16'd0);
    chk("rst_take", 16'(bus.gen_take), 16'd0);
    reset = 1'b0;

    // Fill with 3,1,4,0.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, fill_a[i], 1'b0, 1'b0);
      #1;
      chk("fill_take", 16'(bus.gen_take), 16'd1);
      tick();
    end
    chk("fill_preview", 16'(bus.preview), 16'h021);
    chk("fill_pvalid", 16'(bus.preview_valid), 16'b111);
    drive(1'b1, 3'd5, 1'b0, 1'b0);
    #1;
    chk("full_no_take", 16'(bus.gen_take), 16'd0);
    tick();

    // First spawn from a full queue.
    drive(1'b0, 3'd0, 1'b1, 1'b0);
    tick();
    chk("spawn1_valid", 16'(bus.spawn_valid), 16'd1);
    chk("spawn1_active", 16'(bus.active_piece), 16'd3);
    chk("spawn1_pvalid", 16'(bus.preview_valid), 16'b011);
    chk("spawn1_preview", 16'(bus.preview), 16'h004);
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    chk("spawn1_pulse_end", 16'(bus.spawn_valid), 16'd0);

    // Hold into empty slot: park 3, spawn head 1.
    drive(1'b0, 3'd0, 1'b0, 1'b1);
    tick();
    chk("park_hold", 16'(bus.hold_piece), 16'd3);
    chk("park_hvalid", 16'(bus.hold_valid), 16'd1);
    chk("park_active", 16'(bus.active_piece), 16'd1);
    chk("park_spawn", 16'(bus.spawn_valid), 16'd1);
    chk("park_pvalid", 16'(bus.preview_valid), 16'b001);
    // Second hold before any spawn is ignored.
    tick();
    chk("rehold_active", 16'(bus.active_piece), 16'd1);
    chk("rehold_hold", 16'(bus.hold_piece), 16'd3);
    chk("rehold_spawn", 16'(bus.spawn_valid), 16'd0);
    // Spawn re-arms hold, then swap.
    drive(1'b0, 3'd0, 1'b1, 1'b0);
    tick();
    chk("spawn2_active", 16'(bus.active_piece), 16'd4);
    drive(1'b0, 3'd0, 1'b0, 1'b1);
    tick();
    chk("swap_active", 16'(bus.active_piece), 16'd3);
    chk("swap_hold", 16'(bus.hold_piece), 16'd4);
    chk("swap_spawn", 16'(bus.spawn_valid), 16'd1);
    // Drain last entry.
    drive(1'b0, 3'd0, 1'b1, 1'b0);
    tick();
    chk("drain_active", 16'(bus.active_piece), 16'd0);
    chk("drain_spawn", 16'(bus.spawn_valid), 16'd1);
    // Spawn and hold together on empty queue: spawn wins, enters wait.
    drive(1'b0, 3'd0, 1'b1, 1'b1);
    tick();
    chk("both_spawn", 16'(bus.spawn_valid), 16'd0);
    chk("both_active", 16'(bus.active_piece), 16'd0);
    chk("both_hold", 16'(bus.hold_piece), 16'd4);
    // Hold ignored while waiting.
    drive(1'b0, 3'd0, 1'b0, 1'b1);
    tick();
    chk("wait_hold_ign", 16'(bus.hold_piece), 16'd4);
    chk("wait_active_ign", 16'(bus.active_piece), 16'd0);
    // Illegal code while waiting is taken and dropped.
    drive(1'b1, 3'd7, 1'b0, 1'b0);
    #1;
    chk("wait_bad_take", 16'(bus.gen_take), 16'd1);
    tick();
    chk("wait_bad_err", 16'(bus.err_invalid), 16'd1);
    chk("wait_bad_nospawn", 16'(bus.spawn_valid), 16'd0);
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    chk("wait_err_end", 16'(bus.err_invalid), 16'd0);
    tick();
    // Legal piece routes straight to active.
    drive(1'b1, 3'd6, 1'b0, 1'b0);
    #1;
    chk("wait_take", 16'(bus.gen_take), 16'd1);
    tick();
    chk("wait_active", 16'(bus.active_piece), 16'd6);
    chk("wait_spawn", 16'(bus.spawn_valid), 16'd1);
    chk("wait_pvalid", 16'(bus.preview_valid), 16'b000);

    // Refill with 2,5,1,3.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, fill_b[i], 1'b0, 1'b0);
      tick();
    end
    chk("refill_preview", 16'(bus.preview), 16'h0CD);
    chk("refill_pvalid", 16'(bus.preview_valid), 16'b111);
    // Full queue: pop and capture in the same cycle.
    drive(1'b1, 3'd6, 1'b1, 1'b0);
    #1;
    chk("popcap_take", 16'(bus.gen_take), 16'd1);
    tick();
    chk("popcap_active", 16'(bus.active_piece), 16'd2);
    chk("popcap_pvalid", 16'(bus.preview_valid), 16'b111);
    chk("popcap_preview", 16'(bus.preview), 16'h199);
    drive(1'b0, 3'd0, 1'b1, 1'b0);
    tick();
    chk("spawn3_active", 16'(bus.active_piece), 16'd5);
    chk("spawn3_preview", 16'(bus.preview), 16'h033);
    // Illegal code with room: taken, flagged, count unchanged.
    drive(1'b1, 3'd7, 1'b0, 1'b0);
    #1;
    chk("bad_take", 16'(bus.gen_take), 16'd1);
    tick();
    chk("bad_err", 16'(bus.err_invalid), 16'd1);
    chk("bad_pvalid", 16'(bus.preview_valid), 16'b011);
    chk("bad_preview", 16'(bus.preview), 16'h033);

    // Reset with a pending spawn and piece: nothing is emitted.
    reset = 1'b1;
    drive(1'b1, 3'd6, 1'b1, 1'b0);
    tick();
    chk("rst2_spawn", 16'(bus.spawn_valid), 16'd0);
    chk("rst2_active", 16'(bus.active_piece), 16'd0);
    chk("rst2_hold_valid", 16'(bus.hold_valid), 16'd0);
    chk("rst2_pvalid", 16'(bus.preview_valid), 16'd0);
    chk("rst2_err", 16'(bus.err_invalid), 16'd0);
    reset = 1'b0;
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
